mem_stage: RTL

Memory-access pipeline stage of the 16-bit processor, sitting between the execute stage and register writeback. It consumes the ALU result, store data and control bits, and performs loads/stores on a data memory with a valid/ready handshake. It stalls upstream while an access is outstanding and presents registered writeback data, destination and write-enable to the register file.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
// Control-bit indices, FSM states, default widths and helpers.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int RD_W   = 3;
  localparam int CNT_W  = 8;

  localparam int WBSRC_BIT    = 2;
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 0;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  function automatic logic is_mem_op(
    input logic [2:0] sig
  );
    return sig[MEMREAD_BIT] | sig[MEMWRITE_BIT];
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus.
// master = pipeline stage (req/we/addr/wdata out), slave = memory.
interface mem_stage_if #(
  parameter int DW = 16
);

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage (execute -> writeback).
// Ports: clk/reset, i_* instruction from execute, o_stall to upstream,
// mem (master bus to data memory), o_wb_* registered writeback, o_mem_error.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int RD_WIDTH       = RD_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_AluResult,
  input  logic [DATA_WIDTH-1:0] i_StoreData,
  input  logic [2:0]            i_signals,
  input  logic [RD_WIDTH-1:0]   i_Rd,
  input  logic                  i_RegWrite,

  output logic                  o_stall,

  mem_stage_if.master           mem,

  output logic                  o_wb_valid,
  output logic [DATA_WIDTH-1:0] o_WBData,
  output logic [RD_WIDTH-1:0]   o_wb_rd,
  output logic                  o_wb_RegWrite,
  output logic                  o_mem_error
);

  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e r_state;
  state_e w_next;

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic                  r_wbsrc;
  logic [RD_WIDTH-1:0]   r_rd;
  logic                  r_regwrite;

  logic                  r_wb_valid;
  logic [DATA_WIDTH-1:0] r_wbdata;
  logic [RD_WIDTH-1:0]   r_wb_rd;
  logic                  r_wb_regwrite;
  logic                  r_err;

  logic w_idle;
  logic w_access;
  logic w_mem_op;
  logic w_accept_alu;
  logic w_accept_mem;
  logic w_done;
  logic w_timeout;
  logic w_use_rdata;

  assign w_idle   = (r_state == S_IDLE);
  assign w_access = (r_state == S_ACCESS);
  assign w_mem_op = is_mem_op(i_signals);

  assign w_accept_alu = w_idle & i_in_valid & ~w_mem_op;
  assign w_accept_mem = w_idle & i_in_valid & w_mem_op;

  // Completion wins over timeout on the final cycle.
  assign w_done    = w_access & mem.mem_ready;
  assign w_timeout = w_access & ~mem.mem_ready
                   & (r_cnt == TO_LAST);

  // Stores never return data; WBsrc only matters for reads.
  assign w_use_rdata = ~r_we & r_wbsrc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept_mem) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_done | w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_wbsrc    <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
    end else begin
      if (w_accept_mem) begin
        r_cnt      <= '0;
        r_addr     <= i_AluResult;
        r_wdata    <= i_StoreData;
        r_we       <= i_signals[MEMWRITE_BIT];
        r_wbsrc    <= i_signals[WBSRC_BIT];
        r_rd       <= i_Rd;
        r_regwrite <= i_RegWrite;
      end else if (w_done | w_timeout) begin
        r_cnt <= '0;
      end else if (w_access) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Writeback register; wb_RegWrite is only ever high with wb_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid    <= 1'b0;
      r_wbdata      <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_wb_valid <= w_accept_alu | w_done | w_timeout;
      unique case (1'b1)
        w_accept_alu: begin
          r_wbdata      <= i_AluResult;
          r_wb_rd       <= i_Rd;
          r_wb_regwrite <= i_RegWrite;
        end
        w_done: begin
          r_wbdata      <= w_use_rdata ? mem.mem_rdata
                                       : r_addr;
          r_wb_rd       <= r_rd;
          r_wb_regwrite <= r_regwrite;
        end
        w_timeout: begin
          r_wbdata      <= r_addr;
          r_wb_rd       <= r_rd;
          r_wb_regwrite <= 1'b0;
          r_err         <= 1'b1;
        end
        default: begin
          r_wb_regwrite <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = w_access;
  assign mem.mem_we    = w_access & r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign o_stall       = w_access | w_accept_mem;
  assign o_wb_valid    = r_wb_valid;
  assign o_WBData      = r_wbdata;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_RegWrite = r_wb_regwrite;
  assign o_mem_error   = r_err;

endmodule
